// File: rtl/pipe_hazard_scoreboard.sv
// Hazard, forwarding, flush and interrupt-drain controller for the 5-stage SCPU pipeline.
// Optional single-step debug control is compiled in when DEBUG_STEP_EN is defined.
module pipe_hazard_scoreboard #(
    parameter int NREG      = 32,
    parameter int NSTAGE    = 3,
    parameter int LOAD_LAT  = 1,
    parameter int FLUSH_CYC = 1,
    localparam int RW       = $clog2(NREG),
    localparam int FW       = $clog2(NSTAGE + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_id_valid,
    input  logic [RW-1:0] i_id_rs,
    input  logic [RW-1:0] i_id_rt,
    input  logic          i_id_rs_use,
    input  logic          i_id_rt_use,
    input  logic [RW-1:0] i_id_wr,
    input  logic          i_id_wr_en,
    input  logic          i_id_load,
    input  logic          i_br_taken,
    input  logic          i_int_req,
    input  logic          i_ret_req,
`ifdef DEBUG_STEP_EN
    input  logic          i_debug_en,
    input  logic          i_debug_step,
`endif
    output logic [FW-1:0] o_fwd_a,
    output logic [FW-1:0] o_fwd_b,
    output logic          o_stall,
    output logic          o_if_en,
    output logic          o_id_flush,
    output logic          o_ex_flush,
    output logic          o_int_ack,
    output logic          o_busy
);

    localparam int CW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC + 1) : 1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [NSTAGE:1] r_tag_vld;
    logic [NSTAGE:1] r_tag_ld;
    logic [RW-1:0]   r_tag_wr [1:NSTAGE];
    logic [CW-1:0]   r_flush_cnt;

    logic [FW-1:0]   w_fwd_a;
    logic [FW-1:0]   w_fwd_b;
    logic            w_ld_a;
    logic            w_ld_b;
    logic            w_stall_raw;
    logic            w_id_enter;
    logic            w_advance;

`ifdef DEBUG_STEP_EN
    logic r_dbg_step_q;
    logic r_dbg_pulse;

    // A rising edge of debug_step releases exactly one advance on the following cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_dbg_step_q <= 1'b0;
            r_dbg_pulse  <= 1'b0;
        end else begin
            r_dbg_step_q <= i_debug_step;
            r_dbg_pulse  <= i_debug_step & ~r_dbg_step_q;
        end
    end

    assign w_advance = ~i_debug_en | r_dbg_pulse;
`else
    assign w_advance = 1'b1;
`endif

    // Scan oldest to youngest so the youngest matching producer wins.
    always_comb begin
        w_fwd_a = '0;
        w_fwd_b = '0;
        w_ld_a  = 1'b0;
        w_ld_b  = 1'b0;
        for (int k = NSTAGE; k >= 1; k--) begin
            if (i_id_rs_use && (i_id_rs != '0) && r_tag_vld[k] && (r_tag_wr[k] == i_id_rs)) begin
                w_fwd_a = FW'(k);
                w_ld_a  = r_tag_ld[k] && (k <= LOAD_LAT);
            end
            if (i_id_rt_use && (i_id_rt != '0) && r_tag_vld[k] && (r_tag_wr[k] == i_id_rt)) begin
                w_fwd_b = FW'(k);
                w_ld_b  = r_tag_ld[k] && (k <= LOAD_LAT);
            end
        end
    end

    assign o_fwd_a     = w_fwd_a;
    assign o_fwd_b     = w_fwd_b;
    assign w_stall_raw = i_id_valid & (w_ld_a | w_ld_b);

    always_comb begin
        o_stall    = 1'b0;
        o_if_en    = w_advance;
        o_id_flush = 1'b0;
        o_ex_flush = 1'b0;
        o_int_ack  = (r_state == ST_ACK);
        o_busy     = (r_state != ST_RUN);
        if (i_br_taken) begin
            o_ex_flush = 1'b1;
            o_id_flush = 1'b1;
        end else if (r_state == ST_DRAIN) begin
            o_if_en    = 1'b0;
            o_id_flush = 1'b1;
        end else if (r_state == ST_ACK) begin
            o_id_flush = 1'b1;
        end else if (r_flush_cnt != '0) begin
            o_id_flush = 1'b1;
        end else if (i_ret_req) begin
            o_id_flush = 1'b1;
        end else if (w_stall_raw) begin
            o_stall    = 1'b1;
            o_if_en    = 1'b0;
            o_id_flush = 1'b1;
        end
    end

    // An interrupt waits for any outstanding redirect flush before draining.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:   if (i_int_req && !i_br_taken && (r_flush_cnt == '0)) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (r_tag_vld == '0) w_state_nxt = ST_ACK;
            ST_ACK:   w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_flush_cnt <= '0;
        end else if (i_br_taken) begin
            r_flush_cnt <= CW'(FLUSH_CYC - 1);
        end else if (r_flush_cnt != '0) begin
            r_flush_cnt <= r_flush_cnt - CW'(1);
        end
    end

    assign w_id_enter = i_id_valid & ~o_stall & ~o_id_flush & (r_state == ST_RUN);

    // ID -> EX boundary, then EX -> MEM -> WB shift of producer tags.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_tag_vld <= '0;
        end else if (w_advance) begin
            r_tag_vld[1] <= w_id_enter & i_id_wr_en & (i_id_wr != '0);
            for (int k = 2; k <= NSTAGE; k++) begin
                r_tag_vld[k] <= r_tag_vld[k-1];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_advance) begin
            r_tag_wr[1] <= i_id_wr;
            r_tag_ld[1] <= i_id_load;
            for (int k = 2; k <= NSTAGE; k++) begin
                r_tag_wr[k] <= r_tag_wr[k-1];
                r_tag_ld[k] <= r_tag_ld[k-1];
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Directed bench for pipe_hazard_scoreboard (FLUSH_CYC=2, other parameters default).
module tb_pipe_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_rs_use, id_rt_use, id_wr_en, id_load;
    logic [4:0] id_rs, id_rt, id_wr;
    logic       br_taken, int_req, ret_req;
    logic [1:0] fwd_a, fwd_b;
    logic       stall, if_en, id_flush, ex_flush, int_ack, busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_hazard_scoreboard #(
        .NREG(32), .NSTAGE(3), .LOAD_LAT(1), .FLUSH_CYC(2)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_id_valid(id_valid), .i_id_rs(id_rs), .i_id_rt(id_rt),
        .i_id_rs_use(id_rs_use), .i_id_rt_use(id_rt_use),
        .i_id_wr(id_wr), .i_id_wr_en(id_wr_en), .i_id_load(id_load),
        .i_br_taken(br_taken), .i_int_req(int_req), .i_ret_req(ret_req),
        .o_fwd_a(fwd_a), .o_fwd_b(fwd_b), .o_stall(stall), .o_if_en(if_en),
        .o_id_flush(id_flush), .o_ex_flush(ex_flush), .o_int_ack(int_ack), .o_busy(busy)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_rs = 0; id_rt = 0; id_rs_use = 0; id_rt_use = 0;
        id_wr = 0; id_wr_en = 0; id_load = 0;
        br_taken = 0; int_req = 0; ret_req = 0;
    endtask

    task automatic issue(input logic [4:0] wr, input logic ld);
        idle();
        id_valid = 1; id_wr = wr; id_wr_en = 1; id_load = ld;
    endtask

    task automatic read_ab(input logic [4:0] rs, input logic rsu, input logic [4:0] rt, input logic rtu);
        idle();
        id_valid = 1; id_rs = rs; id_rs_use = rsu; id_rt = rt; id_rt_use = rtu;
    endtask

    initial begin
        idle();
        rst = 0;
        cyc(); cyc();
        #1;
        chk("rst_fwd_a", fwd_a, 0);    chk("rst_fwd_b", fwd_b, 0);
        chk("rst_stall", stall, 0);    chk("rst_if_en", if_en, 1);
        chk("rst_id_flush", id_flush, 0); chk("rst_ex_flush", ex_flush, 0);
        chk("rst_int_ack", int_ack, 0);   chk("rst_busy", busy, 0);
        rst = 1;
        cyc();

        // add r3 forwarded from EX, then MEM, then WB
        issue(5'd3, 0); cyc();
        read_ab(5'd3, 1, 5'd0, 0); #1;
        chk("t1_fwd_a_ex", fwd_a, 1); chk("t1_stall", stall, 0);
        cyc(); chk("t1_fwd_a_mem", fwd_a, 2);
        cyc(); chk("t1_fwd_a_wb", fwd_a, 3);
        cyc(); chk("t1_fwd_a_gone", fwd_a, 0);

        // lw r5 load-use on rt
        issue(5'd5, 1); cyc();
        read_ab(5'd0, 0, 5'd5, 1); #1;
        chk("t2_stall", stall, 1); chk("t2_if_en", if_en, 0);
        chk("t2_id_flush", id_flush, 1); chk("t2_fwd_b_ex", fwd_b, 1);
        cyc();
        chk("t2_stall_done", stall, 0); chk("t2_fwd_b_mem", fwd_b, 2);
        chk("t2_if_en_back", if_en, 1); chk("t2_id_flush_off", id_flush, 0);
        idle(); cyc(); cyc(); cyc();

        // youngest producer wins; r0 never forwards
        issue(5'd4, 0); cyc();
        issue(5'd4, 0); cyc();
        read_ab(5'd4, 1, 5'd0, 1); id_wr = 5'd0; id_wr_en = 1; #1;
        chk("t3_fwd_a_young", fwd_a, 1); chk("t3_fwd_b_r0", fwd_b, 0);
        cyc();
        chk("t3_fwd_a_after_r0", fwd_a, 2); chk("t3_fwd_b_r0_tag", fwd_b, 0);
        idle(); cyc(); cyc(); cyc();

        // redirect overrides a pending load-use stall, id_flush held 2 cycles
        issue(5'd6, 1); cyc();
        read_ab(5'd6, 1, 5'd0, 0); br_taken = 1; #1;
        chk("t4_ex_flush", ex_flush, 1); chk("t4_id_flush", id_flush, 1);
        chk("t4_stall_ignored", stall, 0); chk("t4_if_en", if_en, 1);
        cyc();
        br_taken = 0; #1;
        chk("t4_ex_flush_off", ex_flush, 0); chk("t4_id_flush_hold", id_flush, 1);
        chk("t4_stall_hold", stall, 0); chk("t4_fwd_a_mem", fwd_a, 2);
        cyc();
        chk("t4_id_flush_off", id_flush, 0);
        idle(); cyc(); cyc(); cyc();

        // eret flushes ID for one cycle, instruction never enters EX
        issue(5'd7, 0); ret_req = 1; #1;
        chk("ret_id_flush", id_flush, 1); chk("ret_ex_flush", ex_flush, 0);
        cyc();
        read_ab(5'd7, 1, 5'd0, 0); #1;
        chk("ret_no_tag", fwd_a, 0); chk("ret_id_flush_off", id_flush, 0);

        // interrupt with three producers in flight
        issue(5'd1, 0); cyc();
        issue(5'd2, 0); cyc();
        issue(5'd3, 0); cyc();
        idle(); int_req = 1; #1;
        chk("t5_busy_run", busy, 0); chk("t5_if_en_run", if_en, 1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t5_drain_busy", busy, 1); chk("t5_drain_if_en", if_en, 0);
            chk("t5_drain_id_flush", id_flush, 1); chk("t5_drain_no_ack", int_ack, 0);
        end
        cyc();
        chk("t5_ack", int_ack, 1); chk("t5_ack_if_en", if_en, 1);
        chk("t5_ack_id_flush", id_flush, 1); chk("t5_ack_busy", busy, 1);
        int_req = 0;
        cyc();
        chk("t5_run_busy", busy, 0); chk("t5_run_ack", int_ack, 0);
        chk("t5_run_id_flush", id_flush, 0);

        // reset in the middle of a drain
        issue(5'd8, 0); cyc();
        issue(5'd9, 0); cyc();
        idle(); int_req = 1; cyc();
        chk("t6_drain_busy", busy, 1);
        br_taken = 1; #1;
        chk("t6_drain_br_ex_flush", ex_flush, 1);
        cyc();
        br_taken = 0; #1;
        chk("t6_still_drain", busy, 1); chk("t6_ex_flush_off", ex_flush, 0);
        read_ab(5'd9, 1, 5'd8, 1); int_req = 0; rst = 0;
        cyc();
        rst = 1; #1;
        chk("t6_busy", busy, 0); chk("t6_no_ack", int_ack, 0);
        chk("t6_fwd_a", fwd_a, 0); chk("t6_fwd_b", fwd_b, 0);
        chk("t6_id_flush", id_flush, 0);
        idle(); cyc();
        chk("t6_no_ack_later", int_ack, 0); chk("t6_busy_later", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
